// File: rtl/linescanner_pixel_packer.sv
// linescanner_pixel_packer
// Packs the 8-bit pixel stream from the line-scanner capture unit into 32-bit
// words (pixel 0 in the low byte). It flushes a zero-padded partial word at
// the end of each scan line and hands words to the DMA stage through a
// 2-entry valid/ready buffer. A sticky overflow flag marks dropped words.
// Optional build macro LINESCANNER_PACKER_STATS_EN adds the dropped_pixels
// counter output.
module linescanner_pixel_packer #(
  parameter int LINE_PIXELS = 1024
) (
  input  logic        main_clock_source,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  pixel_data,
  input  logic        pixel_captured,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_line_last,
  output logic        overflow
`ifdef LINESCANNER_PACKER_STATS_EN
  ,
  output logic [15:0] dropped_pixels
`endif
);

  localparam int LW = $clog2(LINE_PIXELS + 1);
  localparam logic [LW-1:0] LAST_IDX = LW'(LINE_PIXELS - 1);

  // Capture-side state
  logic          prev_flag;
  logic [1:0]    byte_idx;
  logic [LW-1:0] line_cnt;
  logic [23:0]   stored;

  // Output buffer state
  logic [31:0]   buf_data [2];
  logic          buf_last [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;

  logic          pix_edge;
  logic          line_end;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          drop;
  logic [31:0]   push_word;

  // Bytes above byte_idx in 'stored' are always zero, so OR-ing the new pixel
  // into its lane gives the zero-padded word directly.
  assign pix_edge  = pixel_captured && !prev_flag && enable;
  assign line_end  = (line_cnt == LAST_IDX);
  assign push      = pix_edge && ((byte_idx == 2'd3) || line_end);
  assign push_word = {8'h00, stored} | ({24'h000000, pixel_data} << {byte_idx, 3'b000});

  assign full    = (count == 2'd2);
  assign pop     = (count != 2'd0) && word_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  assign word_valid     = (count != 2'd0);
  assign word_data      = word_valid ? buf_data[rd_ptr] : 32'h0000_0000;
  assign word_line_last = word_valid ? buf_last[rd_ptr] : 1'b0;

  // Edge detection, byte assembly and line position tracking
  always_ff @(posedge main_clock_source) begin
    if (reset) begin
      prev_flag <= 1'b0;
      byte_idx  <= 2'd0;
      line_cnt  <= '0;
      stored    <= 24'h000000;
    end else begin
      prev_flag <= pixel_captured;
      if (!enable) begin
        byte_idx <= 2'd0;
        line_cnt <= '0;
        stored   <= 24'h000000;
      end else if (pix_edge) begin
        if (push) begin
          byte_idx <= 2'd0;
          stored   <= 24'h000000;
        end else begin
          byte_idx <= byte_idx + 2'd1;
          stored   <= push_word[23:0];
        end
        line_cnt <= line_end ? '0 : line_cnt + 1'b1;
      end
    end
  end

  // Buffer payload storage; contents are only meaningful while counted
  always_ff @(posedge main_clock_source) begin
    if (push_ok) begin
      buf_data[wr_ptr] <= push_word;
      buf_last[wr_ptr] <= line_end;
    end
  end

  // Buffer pointers, occupancy and sticky overflow
  always_ff @(posedge main_clock_source) begin
    if (reset) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef LINESCANNER_PACKER_STATS_EN
  // Saturating add of a dropped word's pixel count
  function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [2:0] inc);
    logic [16:0] sum;
    sum = {1'b0, acc} + {14'h0000, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Count pixels lost in dropped words
  always_ff @(posedge main_clock_source) begin
    if (reset) begin
      dropped_pixels <= 16'h0000;
    end else if (drop) begin
      dropped_pixels <= sat_add16(dropped_pixels, {1'b0, byte_idx} + 3'd1);
    end
  end
`endif

endmodule

// File: tb/tb_linescanner_pixel_packer.sv
// Bench for linescanner_pixel_packer: two instances (8- and 6-pixel lines)
// share one stimulus stream; a scoreboard model predicts each buffer's
// contents and the DUT heads are compared every cycle, plus fixed expected
// words for each scenario.
module tb_linescanner_pixel_packer;

  localparam int LP_A = 8;
  localparam int LP_B = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  pixel_data;
  logic        pixel_captured;
  logic        word_ready;

  logic [31:0] wa, wb;
  logic        va, vb, la, lb, ova, ovb;
`ifdef LINESCANNER_PACKER_STATS_EN
  logic [15:0] dpa, dpb;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Scoreboard: expected buffer contents {line_last, data} per instance
  logic [32:0] mq [2][$];
  logic [32:0] log_a[$];
  logic [32:0] log_b[$];
  int          m_n   [2];
  logic [31:0] m_acc [2];
  bit          m_ovf [2];
  int          m_drop[2];
  bit          m_prev;

  always #5 clk = ~clk;

  linescanner_pixel_packer #(.LINE_PIXELS(LP_A)) u_a (
    .main_clock_source(clk), .reset(reset), .enable(enable),
    .pixel_data(pixel_data), .pixel_captured(pixel_captured),
    .word_data(wa), .word_valid(va), .word_ready(word_ready),
    .word_line_last(la), .overflow(ova)
`ifdef LINESCANNER_PACKER_STATS_EN
    , .dropped_pixels(dpa)
`endif
  );

  linescanner_pixel_packer #(.LINE_PIXELS(LP_B)) u_b (
    .main_clock_source(clk), .reset(reset), .enable(enable),
    .pixel_data(pixel_data), .pixel_captured(pixel_captured),
    .word_data(wb), .word_valid(vb), .word_ready(word_ready),
    .word_line_last(lb), .overflow(ovb)
`ifdef LINESCANNER_PACKER_STATS_EN
    , .dropped_pixels(dpb)
`endif
  );

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: accumulate pixels per line, emit a word every 4 pixels or at line end
  always @(posedge clk) begin : model
    bit e, pop, full, last;
    int k, lp;
    if (reset) begin
      m_prev = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_n[i] = 0; m_acc[i] = 32'h0; m_ovf[i] = 1'b0; m_drop[i] = 0;
        mq[i].delete();
      end
    end else begin
      e = pixel_captured && !m_prev && enable;
      m_prev = pixel_captured;
      for (int i = 0; i < 2; i++) begin
        lp   = (i == 0) ? LP_A : LP_B;
        pop  = word_ready && (mq[i].size() != 0);
        full = (mq[i].size() == 2);
        if (!enable) begin
          m_n[i] = 0; m_acc[i] = 32'h0;
        end else if (e) begin
          m_acc[i] = m_acc[i] | (32'(pixel_data) << (8 * (m_n[i] % 4)));
          m_n[i]++;
          last = (m_n[i] == lp);
          if ((m_n[i] % 4 == 0) || last) begin
            if (full && !pop) begin
              m_ovf[i] = 1'b1;
              k = (m_n[i] - 1) % 4 + 1;
              m_drop[i] = (m_drop[i] + k > 65535) ? 65535 : m_drop[i] + k;
            end else begin
              mq[i].push_back({last, m_acc[i]});
            end
            m_acc[i] = 32'h0;
            if (last) m_n[i] = 0;
          end
        end
        if (pop) void'(mq[i].pop_front());
      end
    end
  end

  // Per-cycle comparison of outputs against the model, and log of transfers
  always @(negedge clk) begin
    if (chk_on) begin
      check("a_valid", 33'(va), 33'(mq[0].size() != 0));
      if (mq[0].size() != 0) check("a_head", {la, wa}, mq[0][0]);
      check("a_overflow", 33'(ova), 33'(m_ovf[0]));
      check("b_valid", 33'(vb), 33'(mq[1].size() != 0));
      if (mq[1].size() != 0) check("b_head", {lb, wb}, mq[1][0]);
      check("b_overflow", 33'(ovb), 33'(m_ovf[1]));
`ifdef LINESCANNER_PACKER_STATS_EN
      check("a_dropped", 33'(dpa), 33'(m_drop[0]));
      check("b_dropped", 33'(dpb), 33'(m_drop[1]));
`endif
      if (!reset && word_ready && va) log_a.push_back({la, wa});
      if (!reset && word_ready && vb) log_b.push_back({lb, wb});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [7:0] d);
    pixel_data = d;
    pixel_captured = 1'b1;
    tick();
    pixel_captured = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    log_a.delete();
    log_b.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 33'(va), 33'h0);
    check({tag, "_data"}, 33'(wa), 33'h0);
    check({tag, "_last"}, 33'(la), 33'h0);
    check({tag, "_ovf"}, 33'(ova), 33'h0);
    check({tag, "_b_valid"}, 33'(vb), 33'h0);
    check({tag, "_b_ovf"}, 33'(ovb), 33'h0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; pixel_data = 8'h00;
    pixel_captured = 1'b0; word_ready = 1'b0;
    tick(); tick();
    check_idle("rst");
`ifdef LINESCANNER_PACKER_STATS_EN
    check("rst_dropped", 33'(dpa), 33'h0);
`endif
    reset = 1'b0;
    enable = 1'b1;
    chk_on = 1'b1;

    // Full line of 8 on instance a
    word_ready = 1'b1;
    for (int i = 1; i <= 8; i++) pix(8'(i));
    repeat (3) tick();
    check("t1_count", 33'(log_a.size()), 33'd2);
    if (log_a.size() == 2) begin
      check("t1_w0", log_a[0], {1'b0, 32'h04030201});
      check("t1_w1", log_a[1], {1'b1, 32'h08070605});
    end

    // 6-pixel line with partial flush on instance b, then new line at byte 0
    do_reset();
    for (int i = 0; i < 6; i++) pix(8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) pix(8'h16 + 8'(i));
    repeat (3) tick();
    check("t2_count", 33'(log_b.size()), 33'd3);
    if (log_b.size() == 3) begin
      check("t2_w0", log_b[0], {1'b0, 32'h13121110});
      check("t2_w1", log_b[1], {1'b1, 32'h00001514});
      check("t2_w2", log_b[2], {1'b0, 32'h19181716});
    end

    // Backpressure: two words held, third dropped
    do_reset();
    word_ready = 1'b0;
    for (int i = 1; i <= 12; i++) pix(8'(i));
    check("t3_ovf", 33'(ova), 33'h1);
    check("t3_head", {la, wa}, {1'b0, 32'h04030201});
`ifdef LINESCANNER_PACKER_STATS_EN
    check("t3_dropped", 33'(dpa), 33'd4);
`endif
    word_ready = 1'b1;
    repeat (5) tick();
    check("t3_drained", 33'(log_a.size()), 33'd2);
    if (log_a.size() == 2) begin
      check("t3_w0", log_a[0], {1'b0, 32'h04030201});
      check("t3_w1", log_a[1], {1'b1, 32'h08070605});
    end
    check("t3_empty", 33'(va), 33'h0);

    // Held-high flag gives one pixel only
    do_reset();
    pixel_data = 8'hAA;
    pixel_captured = 1'b1;
    repeat (10) tick();
    pixel_captured = 1'b0;
    tick();
    pix(8'h01); pix(8'h02); pix(8'h03);
    repeat (2) tick();
    check("t4_count", 33'(log_a.size()), 33'd1);
    if (log_a.size() == 1) check("t4_word", log_a[0], {1'b0, 32'h030201AA});

    // Disable mid-word discards partial bytes
    do_reset();
    pix(8'h11); pix(8'h12);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) pix(8'h21 + 8'(i));
    repeat (2) tick();
    check("t5_count", 33'(log_a.size()), 33'd1);
    if (log_a.size() == 1) check("t5_word", log_a[0], {1'b0, 32'h24232221});

    // Push and pop together while full, then reset mid-line
    do_reset();
    word_ready = 1'b0;
    for (int i = 1; i <= 11; i++) pix(8'(i));
    pixel_data = 8'h0C;
    pixel_captured = 1'b1;
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    pixel_captured = 1'b0;
    tick();
    check("t6_ovf", 33'(ova), 33'h0);
    check("t6_head", {la, wa}, {1'b1, 32'h08070605});
    check("t6_popped", 33'(log_a.size()), 33'd1);
    pix(8'h31);
    reset = 1'b1;
    tick();
    check_idle("t6_rst");
    reset = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
